spi_slave: RTL and testbench

//  SPI responder (mode 0: CPOL=0, CPHA=0, MSB first), counterpart to the on-chip SPI master.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_sync.sv | 36 +++
 rtl/spi_slave.sv | 170 +++++++++++++++++
 tb/tb_spi_slave.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: word widths, FSM encoding,
// bit-counter width and the TX word alignment helper.
package spi_pkg;

    localparam int WIDTH_8  = 8;
    localparam int WIDTH_16 = 16;
    localparam int CNT_W    = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Number of bits in one word for the selected width.
    function automatic logic [CNT_W-1:0] word_bits(input logic w16);
        return w16 ? CNT_W'(WIDTH_16) : CNT_W'(WIDTH_8);
    endfunction

    // TX words are kept MSB-aligned in the 16-bit shifter so miso always
    // comes from bit 15, whatever the word width.
    function automatic logic [15:0] load_word(input logic w16, input logic [15:0] data);
        return w16 ? data : {data[7:0], 8'h00};
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Input synchronizer with edge detection. STAGES flops (minimum 2) bring an
// asynchronous pin into the raw_clk domain; one further flop holds the
// previous synchronized value so rising and falling edges can be flagged.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic raw_clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchronizer chain and keep one delayed copy.
    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge value, so the chain really is STAGES flops deep.
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder, mode 0 (CPOL=0, CPHA=0), MSB first, 8- or 16-bit words.
// sclk, cs_n and mosi are oversampled in the raw_clk domain.
// Optional feature: define SPI_SLAVE_OVERRUN_EN to add the rx_read input and
// the sticky overrun output (word completed while the previous one unread).
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        raw_clk,
    input  logic        reset_n,
    input  logic        width_16,
    input  logic [15:0] data_tx,
    output logic        tx_ack,
    output logic [15:0] data_rx,
    output logic        rx_valid,
    output logic        busy,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    input  logic        rx_read,
    output logic        overrun
`endif
);

    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic cs_rise, cs_fall, cs_level_unused;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .raw_clk (raw_clk),
        .reset_n (reset_n),
        .din     (sclk),
        .level   (sclk_level_unused),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    // cs_n resets to the deselected level so reset release never looks like a select.
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .raw_clk (raw_clk),
        .reset_n (reset_n),
        .din     (cs_n),
        .level   (cs_level_unused),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .raw_clk (raw_clk),
        .reset_n (reset_n),
        .din     (mosi),
        .level   (mosi_level),
        .rise    (mosi_rise_unused),
        .fall    (mosi_fall_unused)
    );

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic              w16_q;
    logic [15:0]       tx_buf;
    logic [14:0]       rx_buf;
    logic [15:0]       rx_word;
    logic              word_end;

    // Assemble the completed word and flag the sclk rise that finishes it.
    always_comb begin
        // NOTE: every output of this block gets a value before any condition,
        // so no path can leave one unassigned and infer a latch.
        rx_word  = {rx_buf, mosi_level};
        word_end = 1'b0;
        if (!w16_q) begin
            rx_word[15:8] = 8'h00;
        end
        if (state == ST_SHIFT && sclk_rise && (count + CNT_W'(1)) == word_bits(w16_q)) begin
            word_end = 1'b1;
        end
    end

    // Select/shift FSM with registered SPI and handshake outputs.
    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            w16_q    <= 1'b0;
            tx_buf   <= '0;
            rx_buf   <= '0;
            miso     <= 1'b0;
            busy     <= 1'b0;
            tx_ack   <= 1'b0;
            rx_valid <= 1'b0;
            data_rx  <= '0;
        end else begin
            tx_ack   <= 1'b0;
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state  <= ST_SHIFT;
                        w16_q  <= width_16;
                        tx_buf <= load_word(width_16, data_tx);
                        miso   <= width_16 ? data_tx[15] : data_tx[7];
                        tx_ack <= 1'b1;
                        count  <= '0;
                        busy   <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        rx_buf <= {rx_buf[13:0], mosi_level};
                        if (word_end) begin
                            data_rx  <= rx_word;
                            rx_valid <= 1'b1;
                            tx_buf   <= load_word(w16_q, data_tx);
                            tx_ack   <= 1'b1;
                            count    <= '0;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end else if (sclk_fall) begin
                        // A fall with count at zero follows a reload: present
                        // the fresh MSB instead of shifting it away.
                        if (count == '0) begin
                            miso <= tx_buf[15];
                        end else begin
                            tx_buf <= {tx_buf[14:0], 1'b0};
                            miso   <= tx_buf[14];
                        end
                    end
                    // Deselect wins over the shift bookkeeping, but a word
                    // finishing on the same cycle is still delivered above.
                    if (cs_rise) begin
                        state <= ST_IDLE;
                        miso  <= 1'b0;
                        busy  <= 1'b0;
                        count <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic pending;

    // Track unread words and latch an overrun when one is overwritten.
    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (rx_valid) begin
                pending <= 1'b1;
            end else if (rx_read) begin
                pending <= 1'b0;
            end
            if (word_end && pending) begin
                overrun <= 1'b1;
            end else if (rx_read && !rx_valid) begin
                overrun <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bench-side SPI master drives words,
// the expected rx words are simply the words the master sent and the expected
// miso words are the data_tx sequence the bench offered, one per tx_ack.
module tb_spi_slave;

    localparam int HALF = 6;  // raw_clk cycles per sclk phase

    logic        raw_clk  = 1'b0;
    logic        reset_n  = 1'b0;
    logic        width_16 = 1'b0;
    logic [15:0] data_tx  = 16'h0000;
    logic        sclk     = 1'b0;
    logic        cs_n     = 1'b1;
    logic        mosi     = 1'b0;
    logic        tx_ack, rx_valid, busy, miso;
    logic [15:0] data_rx;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic        rx_read  = 1'b0;
    logic        overrun;
`endif

    spi_slave #(.SYNC_STAGES(2)) dut (
        .raw_clk  (raw_clk),
        .reset_n  (reset_n),
        .width_16 (width_16),
        .data_tx  (data_tx),
        .tx_ack   (tx_ack),
        .data_rx  (data_rx),
        .rx_valid (rx_valid),
        .busy     (busy),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso)
`ifdef SPI_SLAVE_OVERRUN_EN
        ,
        .rx_read  (rx_read),
        .overrun  (overrun)
`endif
    );

    always #5 raw_clk = ~raw_clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] tx_list[$];
    logic [15:0] mosi_list[$];
    logic [15:0] miso_got[$];
    logic [15:0] rx_q[$];
    int          tx_idx   = 0;
    int          ack_cnt  = 0;
    bit          miso_seen = 1'b0;
    logic [15:0] last_rx_exp = 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Advance n raw_clk cycles, observing outputs on the falling edge and
    // offering the next TX word whenever the responder acknowledges one.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge raw_clk);
            if (miso) miso_seen = 1'b1;
            if (rx_valid) rx_q.push_back(data_rx);
            if (tx_ack) begin
                ack_cnt++;
                tx_idx++;
                data_tx = (tx_idx < tx_list.size()) ? tx_list[tx_idx] : 16'h0000;
            end
        end
    endtask

    // One mode-0 bit: set mosi, raise sclk (master samples miso), lower sclk.
    task automatic sclk_bit(input logic b, output logic sampled);
        mosi = b;
        tick(HALF);
        sclk = 1'b1;
        sampled = miso;
        tick(HALF);
        sclk = 1'b0;
    endtask

    task automatic start_select(input bit w16);
        rx_q.delete();
        miso_got.delete();
        ack_cnt  = 0;
        tx_idx   = 0;
        data_tx  = tx_list[0];
        width_16 = w16;
        tick(4);
        cs_n = 1'b0;
        tick(8);
        check("busy_selected", 32'(busy), 32'd1);
        width_16 = ~w16;  // must be ignored until the next select
    endtask

    task automatic end_select();
        tick(HALF);
        cs_n = 1'b1;
        tick(8);
        check("busy_released", 32'(busy), 32'd0);
        check("miso_released", 32'(miso), 32'd0);
    endtask

    // Full select of nw words from mosi_list, then score against the model.
    task automatic run_full(input bit w16, input int nw, input string tag);
        int          bits;
        logic [15:0] word, got, exp;
        logic        s;
        bits = w16 ? 16 : 8;
        start_select(w16);
        for (int w = 0; w < nw; w++) begin
            word = mosi_list[w];
            got  = 16'h0000;
            for (int b = bits - 1; b >= 0; b--) begin
                sclk_bit(word[b], s);
                got = {got[14:0], s};
            end
            miso_got.push_back(got);
        end
        end_select();
        check({tag, "_rx_count"}, 32'(rx_q.size()), 32'(nw));
        check({tag, "_tx_acks"}, 32'(ack_cnt), 32'(nw + 1));
        for (int w = 0; w < nw; w++) begin
            exp = w16 ? mosi_list[w] : {8'h00, mosi_list[w][7:0]};
            if (w < rx_q.size()) check({tag, "_rx_word"}, 32'(rx_q[w]), 32'(exp));
            exp = w16 ? tx_list[w] : {8'h00, tx_list[w][7:0]};
            check({tag, "_miso_word"}, 32'(miso_got[w]), 32'(exp));
            last_rx_exp = w16 ? mosi_list[w] : {8'h00, mosi_list[w][7:0]};
        end
        check({tag, "_data_rx_hold"}, 32'(data_rx), 32'(last_rx_exp));
    endtask

    initial begin
        logic s;
        bit   w16;
        int   nw;

        // Reset state
        tick(3);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_ack", 32'(tx_ack), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_data_rx", 32'(data_rx), 32'd0);
        reset_n = 1'b1;
        tick(5);

        // 8-bit single word
        tx_list   = '{16'h00A5, 16'h0000};
        mosi_list = '{16'h003C};
        run_full(1'b0, 1, "t8");

        // 16-bit back-to-back words in one select
        tx_list   = '{16'hBEEF, 16'h1234, 16'h0000};
        mosi_list = '{16'hCAFE, 16'h0F0F};
        run_full(1'b1, 2, "t16");

        // Abort after 5 rises: partial word discarded
        tx_list = '{16'h00FF, 16'h0000};
        start_select(1'b0);
        for (int i = 0; i < 5; i++) sclk_bit(i[0], s);
        end_select();
        check("abort_rx_count", 32'(rx_q.size()), 32'd0);
        check("abort_data_rx", 32'(data_rx), 32'(last_rx_exp));
        check("abort_tx_acks", 32'(ack_cnt), 32'd1);

        // sclk noise while deselected
        ack_cnt = 0;
        rx_q.delete();
        miso_seen = 1'b0;
        for (int i = 0; i < 20; i++) sclk_bit(1'($urandom), s);
        tick(8);
        check("idle_tx_acks", 32'(ack_cnt), 32'd0);
        check("idle_rx_count", 32'(rx_q.size()), 32'd0);
        check("idle_miso_activity", 32'(miso_seen), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Reset mid-word clears outputs at once
        tx_list = '{16'hFFFF, 16'h0000};
        start_select(1'b1);
        for (int i = 0; i < 3; i++) sclk_bit(1'b1, s);
        reset_n = 1'b0;
        #1;
        check("midrst_miso", 32'(miso), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tx_ack", 32'(tx_ack), 32'd0);
        check("midrst_rx_valid", 32'(rx_valid), 32'd0);
        check("midrst_data_rx", 32'(data_rx), 32'd0);
`ifdef SPI_SLAVE_OVERRUN_EN
        check("midrst_overrun", 32'(overrun), 32'd0);
`endif
        cs_n = 1'b1;
        sclk = 1'b0;
        tick(4);
        reset_n = 1'b1;
        tick(6);
        last_rx_exp = 16'h0000;
        tx_list   = '{16'h5AC3, 16'h0000};
        mosi_list = '{16'h96E1};
        run_full(1'b1, 1, "after_rst");

`ifdef SPI_SLAVE_OVERRUN_EN
        // Two words without reading: overrun sticks until rx_read
        tx_list   = '{16'h0011, 16'h0022, 16'h0000};
        mosi_list = '{16'h0033, 16'h0044};
        run_full(1'b0, 2, "ovr");
        check("ovr_set", 32'(overrun), 32'd1);
        rx_read = 1'b1;
        tick(1);
        rx_read = 1'b0;
        tick(1);
        check("ovr_cleared", 32'(overrun), 32'd0);
`endif

        // Randomized selects
        for (int it = 0; it < 12; it++) begin
            w16 = 1'($urandom);
            nw  = $urandom_range(1, 3);
            tx_list.delete();
            mosi_list.delete();
            for (int k = 0; k <= nw; k++) tx_list.push_back(16'($urandom));
            for (int k = 0; k < nw; k++) mosi_list.push_back(16'($urandom));
            run_full(w16, nw, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
